// File: rtl/pool_window_2x2_if.sv
// Pixel-in / window-out handshake bundle for the 2x2 window former.
// slave is the window former itself, master is whoever drives and drains it.
interface pool_window_2x2_if #(
    parameter int DATA_WIDTH = 32
);
    logic                         valid_i;
    logic signed [DATA_WIDTH-1:0] data_i;
    logic                         ready_o;
    logic                         valid_o;
    logic signed [DATA_WIDTH-1:0] window_o [0:3];
    logic                         last_o;
    logic                         ready_i;

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, window_o, last_o
    );

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, window_o, last_o
    );
endinterface

// File: rtl/pool_window_2x2.sv
// Raster-order pixel stream to stride-2 2x2 windows for the max-pool stage.
// One row is buffered; the odd row completes each window with hold + data_i.
module pool_window_2x2 #(
    parameter int DATA_WIDTH = 32,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input logic              clk_i,
    input logic              rst_i,
    pool_window_2x2_if.slave s
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_MAX  = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX  = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] LAST_COL = CW'(2 * (IMG_WIDTH / 2) - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(2 * (IMG_HEIGHT / 2) - 1);

    typedef logic signed [DATA_WIDTH-1:0] pix_t;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] col_pair;
    pix_t          line_buf [IMG_WIDTH];
    pix_t          hold;
    pix_t          win [4];
    logic          vld;
    logic          lst;
    logic          ready;
    logic          accept;
    logic          emit;

    always_comb begin
        ready    = !vld || s.ready_i;
        accept   = s.valid_i && ready;
        emit     = accept && row[0] && col[0];
        col_pair = col & ~CW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col  <= '0;
            row  <= '0;
            hold <= '0;
        end else if (accept) begin
            if (col == COL_MAX) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
            if (row[0] && !col[0]) begin
                hold <= s.data_i;
            end
        end
    end

    // Line buffer carries no reset; every entry is rewritten before use.
    always_ff @(posedge clk_i) begin
        if (accept && !row[0]) begin
            line_buf[col] <= s.data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld <= 1'b0;
            lst <= 1'b0;
            win <= '{default: '0};
        end else if (emit) begin
            vld <= 1'b1;
            lst <= (row == LAST_ROW) && (col == LAST_COL);
            win <= '{line_buf[col_pair], line_buf[col], hold, s.data_i};
        end else if (vld && s.ready_i) begin
            vld <= 1'b0;
            lst <= 1'b0;
        end
    end

    assign s.ready_o  = ready;
    assign s.valid_o  = vld;
    assign s.last_o   = lst;
    assign s.window_o = win;
endmodule

// File: tb/tb_pool_window_2x2.sv
// Bench for pool_window_2x2: frame-level model checked every cycle
// on a 4x4 and a 5x5 instance, plus literal window expectations.
module tb_pool_window_2x2;
    typedef logic signed [31:0] px_t;
    typedef struct packed {
        logic last;
        px_t  a;
        px_t  b;
        px_t  c;
        px_t  d;
    } win_t;

    logic clk;
    logic rst;
    bit   armed;
    int   checks;
    int   errors;

    pool_window_2x2_if #(.DATA_WIDTH(32)) ifa ();
    pool_window_2x2_if #(.DATA_WIDTH(32)) ifb ();

    pool_window_2x2 #(
        .DATA_WIDTH(32), .IMG_WIDTH(4), .IMG_HEIGHT(4)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .s(ifa)
    );

    pool_window_2x2 #(
        .DATA_WIDTH(32), .IMG_WIDTH(5), .IMG_HEIGHT(5)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .s(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: pixel count in frame, frame image, expected output register
    int   mk [2];
    bit   mv [2];
    bit   ml [2];
    px_t  mw [2][4];
    px_t  pix [2][5][5];
    win_t qa [$];
    win_t qb [$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(
        input int id, input int w, input int h,
        input logic r, input logic vi, input px_t di, input logic ri,
        input logic ro, input logic vo, input logic lo,
        input px_t w0, input px_t w1, input px_t w2, input px_t w3
    );
        bit   rdy;
        int   rr;
        int   cc;
        win_t e;
        chk($sformatf("valid_o[%0d]", id), longint'(vo), longint'(mv[id]));
        chk($sformatf("last_o[%0d]", id), longint'(lo), longint'(ml[id]));
        chk($sformatf("win0[%0d]", id), longint'(w0), longint'(mw[id][0]));
        chk($sformatf("win1[%0d]", id), longint'(w1), longint'(mw[id][1]));
        chk($sformatf("win2[%0d]", id), longint'(w2), longint'(mw[id][2]));
        chk($sformatf("win3[%0d]", id), longint'(w3), longint'(mw[id][3]));
        rdy = !mv[id] || ri;
        chk($sformatf("ready_o[%0d]", id), longint'(ro), longint'(rdy));
        if (r) begin
            mk[id] = 0;
            mv[id] = 1'b0;
            ml[id] = 1'b0;
            for (int i = 0; i < 4; i++) mw[id][i] = '0;
        end else begin
            if (mv[id] && ri) begin
                mv[id] = 1'b0;
                ml[id] = 1'b0;
            end
            if (vi && rdy) begin
                rr = mk[id] / w;
                cc = mk[id] % w;
                pix[id][rr][cc] = di;
                if ((rr % 2 == 1) && (cc % 2 == 1)) begin
                    mw[id][0] = pix[id][rr-1][cc-1];
                    mw[id][1] = pix[id][rr-1][cc];
                    mw[id][2] = pix[id][rr][cc-1];
                    mw[id][3] = di;
                    mv[id] = 1'b1;
                    ml[id] = (rr == 2 * (h / 2) - 1) && (cc == 2 * (w / 2) - 1);
                    e = '{ml[id], mw[id][0], mw[id][1], mw[id][2], mw[id][3]};
                    if (id == 0) qa.push_back(e);
                    else qb.push_back(e);
                end
                mk[id] = (mk[id] + 1) % (w * h);
            end
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            step(0, 4, 4, rst, ifa.valid_i, ifa.data_i, ifa.ready_i,
                 ifa.ready_o, ifa.valid_o, ifa.last_o,
                 ifa.window_o[0], ifa.window_o[1], ifa.window_o[2], ifa.window_o[3]);
            step(1, 5, 5, rst, ifb.valid_i, ifb.data_i, ifb.ready_i,
                 ifb.ready_o, ifb.valid_o, ifb.last_o,
                 ifb.window_o[0], ifb.window_o[1], ifb.window_o[2], ifb.window_o[3]);
        end
    end

    task automatic send(input int id, input px_t p);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        if (id == 0) begin
            ifa.valid_i = 1'b1;
            ifa.data_i  = p;
        end else begin
            ifb.valid_i = 1'b1;
            ifb.data_i  = p;
        end
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = (id == 0) ? ifa.ready_o : ifb.ready_o;
            @(posedge clk);
            #1;
            n++;
        end
        chk($sformatf("send_timeout[%0d]", id), longint'(acc), 1);
    endtask

    task automatic idle(input int n);
        ifa.valid_i = 1'b0;
        ifb.valid_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_win(
        input int id, input int idx,
        input px_t a, input px_t b, input px_t c, input px_t d, input bit l
    );
        win_t e;
        int   sz;
        sz = (id == 0) ? qa.size() : qb.size();
        chk($sformatf("win_exists[%0d][%0d]", id, idx), longint'(idx < sz), 1);
        if (idx < sz) begin
            e = (id == 0) ? qa[idx] : qb[idx];
            chk($sformatf("lit_a[%0d][%0d]", id, idx), longint'(e.a), longint'(a));
            chk($sformatf("lit_b[%0d][%0d]", id, idx), longint'(e.b), longint'(b));
            chk($sformatf("lit_c[%0d][%0d]", id, idx), longint'(e.c), longint'(c));
            chk($sformatf("lit_d[%0d][%0d]", id, idx), longint'(e.d), longint'(d));
            chk($sformatf("lit_last[%0d][%0d]", id, idx), longint'(e.last), longint'(l));
        end
    endtask

    task automatic chk_4x4(input int base);
        chk("count_4x4", longint'(qa.size()), 4);
        chk_win(0, 0, base + 0, base + 1, base + 4, base + 5, 1'b0);
        chk_win(0, 1, base + 2, base + 3, base + 6, base + 7, 1'b0);
        chk_win(0, 2, base + 8, base + 9, base + 12, base + 13, 1'b0);
        chk_win(0, 3, base + 10, base + 11, base + 14, base + 15, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        armed  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mk[i] = 0;
            mv[i] = 1'b0;
            ml[i] = 1'b0;
            for (int j = 0; j < 4; j++) mw[i][j] = '0;
        end
        rst = 1'b1;
        ifa.valid_i = 1'b0;
        ifa.data_i  = '0;
        ifa.ready_i = 1'b1;
        ifb.valid_i = 1'b0;
        ifb.data_i  = '0;
        ifb.ready_i = 1'b1;
        @(posedge clk);
        #1;
        armed = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_valid", longint'(ifa.valid_o), 0);
        chk("rst_last", longint'(ifa.last_o), 0);
        chk("rst_ready", longint'(ifa.ready_o), 1);
        chk("rst_win0", longint'(ifa.window_o[0]), 0);
        chk("rst_win3", longint'(ifb.window_o[3]), 0);

        // Plain 4x4 ramp
        qa.delete();
        for (int i = 0; i < 16; i++) send(0, px_t'(i));
        idle(4);
        chk_4x4(0);

        // Same frame with a 5-cycle stall on the first window
        qa.delete();
        fork
            begin
                for (int i = 0; i < 16; i++) send(0, px_t'(i));
                ifa.valid_i = 1'b0;
            end
            begin
                int n;
                n = 0;
                while (n < 200) begin
                    @(posedge clk);
                    #1;
                    n++;
                    if (ifa.valid_o) break;
                end
                chk("stall_saw_valid", longint'(ifa.valid_o), 1);
                ifa.ready_i = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_ready_o", longint'(ifa.ready_o), 0);
                    chk("stall_win0", longint'(ifa.window_o[0]), 0);
                    chk("stall_win3", longint'(ifa.window_o[3]), 5);
                end
                @(posedge clk);
                #1;
                ifa.ready_i = 1'b1;
            end
        join
        idle(4);
        chk_4x4(0);

        // Negated ramp keeps sign bits intact
        qa.delete();
        for (int i = 0; i < 16; i++) send(0, -px_t'(i));
        idle(4);
        chk("count_signed", longint'(qa.size()), 4);
        chk_win(0, 0, 0, -1, -4, -5, 1'b0);
        chk_win(0, 3, -10, -11, -14, -15, 1'b1);

        // 5x5 drops the trailing column and row
        qb.delete();
        for (int i = 0; i < 25; i++) send(1, px_t'(i));
        idle(4);
        chk("count_5x5", longint'(qb.size()), 4);
        chk_win(1, 0, 0, 1, 5, 6, 1'b0);
        chk_win(1, 1, 2, 3, 7, 8, 1'b0);
        chk_win(1, 2, 10, 11, 15, 16, 1'b0);
        chk_win(1, 3, 12, 13, 17, 18, 1'b1);

        // Reset mid-frame, then a fresh frame
        for (int i = 0; i < 6; i++) send(0, px_t'(i));
        ifa.valid_i = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        qa.delete();
        chk("post_rst_valid", longint'(ifa.valid_o), 0);
        for (int i = 0; i < 16; i++) send(0, px_t'(100 + i));
        idle(4);
        chk_4x4(100);

        // Two frames back-to-back
        qa.delete();
        for (int i = 0; i < 32; i++) send(0, px_t'(i % 16));
        idle(4);
        chk("count_b2b", longint'(qa.size()), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < qa.size()) begin
                chk($sformatf("b2b_last%0d", i), longint'(qa[i].last),
                    longint'(i == 3 || i == 7));
            end
        end
        chk_win(0, 4, 0, 1, 4, 5, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pool_window_2x2.md
# pool_window_2x2

Streaming window former that sits directly upstream of the 2x2 max-pool stage. It accepts one feature-map pixel per handshake in raster order (row-major, column 0 first). It buffers one image row and emits each non-overlapping, stride-2 2x2 window as four parallel signed words, ready to drive the max-pool's four-element input array. The window output is registered and carries a valid/ready handshake and an end-of-frame flag, so it can be stalled by the downstream consumer.

## Interface
- DATA_WIDTH, 32, width of one signed pixel.
- IMG_WIDTH, 28, pixels per row; must be ≥ 2.
- IMG_HEIGHT, 28, rows per frame; must be ≥ 2.
- clk_i  input  1  sole clock; all state updates on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  input pixel valid.
- data_i  input  signed DATA_WIDTH  input pixel.
- ready_o  output  1  block can accept a pixel this cycle.
- valid_o  output  1  window_o holds a complete window.
- window_o  output  signed DATA_WIDTH, array [0:3]  [0] top-left, [1] top-right, [2] bottom-left, [3] bottom-right.
- last_o  output  1  the current window is the final window of the frame.
- ready_i  input  1  downstream consumes the window when valid_o is also high.

## Operation
- Accept condition: valid_i && ready_o. Pixel state advances only on accept.
- ready_o = !valid_o || ready_i. This is combinational. A full output register that is not being drained blocks input.
- col counter runs 0..IMG_WIDTH-1 and row counter runs 0..IMG_HEIGHT-1.
  - On accept, col increments.
  - When col = IMG_WIDTH-1, col wraps to 0 and row increments.
  - When row = IMG_HEIGHT-1 and col = IMG_WIDTH-1, both wrap to 0 (new frame).
- Line buffer: IMG_WIDTH entries of DATA_WIDTH, not reset. On accept with row even, line_buf[col] <= data_i.
- Hold register: on accept with row odd and col even, hold <= data_i.
- Window emit on accept with row odd and col odd:
  - window_o <= {line_buf[col-1], line_buf[col], hold, data_i}.
  - valid_o <= 1.
  - last_o <= 1 iff this is the final window of the frame. That is the window at row = 2*floor(IMG_HEIGHT/2)-1 and col = 2*floor(IMG_WIDTH/2)-1.
- Odd dimensions (floor behaviour):
  - A trailing column with even index in each row is accepted and discarded; no window is formed.
  - A trailing even row is accepted and written to the line buffer, but never emitted.
  - Counters still wrap at the full IMG_WIDTH / IMG_HEIGHT.
- Output register:
  - If valid_o && ready_i and no new window is emitted this cycle, valid_o <= 0 and last_o <= 0.
  - A new emit in the same cycle as a drain overwrites the register; valid_o stays 1.
  - window_o holds its value while valid_o is 0.
- Window values are passed through unmodified. There is no arithmetic on data and no sign change.
- Windows per frame: floor(IMG_WIDTH/2) * floor(IMG_HEIGHT/2).

## Timing
- Reset (rst_i high at a clock edge): col = 0, row = 0, valid_o = 0, last_o = 0, window_o all zero, hold = 0. Line buffer contents are don't-care.
- ready_o is 1 in the cycle after reset.
- Reset mid-frame discards the partial frame. The next accepted pixel is treated as row 0, col 0. No window from the aborted frame appears after reset.
- Latency: valid_o rises in the cycle after the accept of the bottom-right pixel.
- Throughput: one pixel per cycle while ready_i is held at 1. Back-to-back windows are 2 cycles apart within a row pair.
- Stall: while valid_o = 1 and ready_i = 0:
  - ready_o = 0.
  - Counters, hold and line buffer are frozen.
  - window_o and last_o are stable.
- valid_i while ready_o = 0 is ignored. The source must hold data_i until it is accepted.
- Frames are back-to-back. The first pixel of frame N+1 may be accepted in the same cycle the last window of frame N is drained.

## Test plan
- 4x4 frame, pixels 0..15, ready_i = 1 → exactly four windows, each one cycle after its bottom-right pixel is accepted:
  - {0,1,4,5}
  - {2,3,6,7}
  - {8,9,12,13}
  - {10,11,14,15}
  - last_o = 1 only on the fourth window.
- Same 4x4 frame, ready_i = 0 for 5 cycles when the first window appears → window {0,1,4,5} is held stable; ready_o = 0; no pixels are lost; subsequent windows are unchanged.
- IMG_WIDTH = 5, IMG_HEIGHT = 5, pixels 0..24 → windows:
  - {0,1,5,6}
  - {2,3,7,8}
  - {10,11,15,16}
  - {12,13,17,18}
  - last_o on {12,13,17,18}
  - Pixels 4, 9, 14, 19 and 20..24 produce no output.
- Signed data on 4x4: pixels are the negated ramp 0, -1, ..., -15 → first window is {0,-1,-4,-5} with bit patterns preserved exactly.
- Reset after 6 pixels of a 4x4 frame, then a full frame 100..115 → only the windows {100,101,104,105}, {102,103,106,107}, {108,109,112,113} and {110,111,114,115} appear, with last_o on the fourth.
- Two 4x4 frames streamed back-to-back with valid_i = 1 continuously → 8 windows; last_o on the 4th and 8th windows only.
